// File: rtl/hazard_scoreboard.sv
// Forwarding/hazard scoreboard tracking in-flight instructions from EX (slot 1) to WB (slot DEPTH).
// Optional build macro HZD_ZERO_REG_EN: register 0 never matches, so it is never forwarded or stalled on.
module hazard_scoreboard #(
    parameter int REG_ADDR_W = 3,
    parameter int DEPTH      = 3,
    parameter int LOAD_STAGE = 2,
    parameter int CNT_W      = 16,
    localparam int FW        = $clog2(DEPTH + 1)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  id_valid,
    input  logic [REG_ADDR_W-1:0] id_rs1,
    input  logic [REG_ADDR_W-1:0] id_rs2,
    input  logic                  id_use_rs1,
    input  logic                  id_use_rs2,
    input  logic [REG_ADDR_W-1:0] id_rd,
    input  logic                  id_regwr,
    input  logic                  id_memrd,
    input  logic                  flush,
    input  logic                  mem_wait,
    input  logic                  cnt_clr,
    output logic                  stall,
    output logic [FW-1:0]         fwd_a,
    output logic [FW-1:0]         fwd_b,
    output logic [CNT_W-1:0]      stall_cnt
);

    logic [DEPTH:1]          slot_valid;
    logic [DEPTH:1]          slot_regwr;
    logic [DEPTH:1]          slot_memrd;
    logic [REG_ADDR_W-1:0]   slot_rd [1:DEPTH];

    logic [DEPTH:1]          hit_a;
    logic [DEPTH:1]          hit_b;
    logic                    src_ok_a;
    logic                    src_ok_b;
    logic [FW-1:0]           sel_a;
    logic [FW-1:0]           sel_b;
    logic                    haz_a;
    logic                    haz_b;
    logic                    load_use;
    logic                    issue;

`ifdef HZD_ZERO_REG_EN
    assign src_ok_a = (id_rs1 != '0);
    assign src_ok_b = (id_rs2 != '0);
`else
    assign src_ok_a = 1'b1;
    assign src_ok_b = 1'b1;
`endif

    always_comb begin
        hit_a = '0;
        hit_b = '0;
        for (int k = 1; k <= DEPTH; k++) begin
            hit_a[k] = slot_valid[k] & slot_regwr[k] & id_use_rs1 & src_ok_a & (slot_rd[k] == id_rs1);
            hit_b[k] = slot_valid[k] & slot_regwr[k] & id_use_rs2 & src_ok_b & (slot_rd[k] == id_rs2);
        end
    end

    // Scan oldest to youngest so the youngest match overwrites; only its memrd decides the hazard.
    always_comb begin
        sel_a = '0;
        sel_b = '0;
        haz_a = 1'b0;
        haz_b = 1'b0;
        for (int k = DEPTH; k >= 1; k--) begin
            if (hit_a[k]) begin
                sel_a = FW'(k);
                haz_a = slot_memrd[k] && (k < LOAD_STAGE);
            end
            if (hit_b[k]) begin
                sel_b = FW'(k);
                haz_b = slot_memrd[k] && (k < LOAD_STAGE);
            end
        end
    end

    assign load_use = haz_a | haz_b;
    assign fwd_a    = load_use ? '0 : sel_a;
    assign fwd_b    = load_use ? '0 : sel_b;
    assign stall    = mem_wait | (load_use & id_valid & ~flush);
    assign issue    = id_valid & ~flush & ~load_use;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            slot_valid <= '0;
            slot_regwr <= '0;
            slot_memrd <= '0;
            for (int k = 1; k <= DEPTH; k++) begin
                slot_rd[k] <= '0;
            end
        end else if (!mem_wait) begin
            for (int k = DEPTH; k >= 2; k--) begin
                slot_valid[k] <= slot_valid[k-1];
                slot_regwr[k] <= slot_regwr[k-1];
                slot_memrd[k] <= slot_memrd[k-1];
                slot_rd[k]    <= slot_rd[k-1];
            end
            slot_valid[1] <= issue;
            slot_regwr[1] <= id_regwr;
            slot_memrd[1] <= id_memrd;
            slot_rd[1]    <= id_rd;
        end
    end

    // Clear has priority over a same-cycle stall; the counter sticks at all-ones.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stall_cnt <= '0;
        end else if (cnt_clr) begin
            stall_cnt <= '0;
        end else if (stall && (stall_cnt != '1)) begin
            stall_cnt <= stall_cnt + 1'b1;
        end
    end

endmodule
